adrv9001_tx_serdes_unpack: RTL
==============================

ADRV9001_TX_SERDES_UNPACK -- requirements
Module: adrv9001_tx_serdes_unpack

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input FIFO entries; power of two, >= 2.
REQ-002 Parameter FIFO_PRIME, default 2, FIFO fill level needed before output starts; 1..FIFO_DEPTH.
REQ-003 Parameter CNT_WIDTH, default 16, width of the underflow counter.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  run request; low drains the current sample, then idles.
REQ-007 mode  input  1  0 = 16-bit I/Q, two beats per sample; 1 = 8-bit I/Q, one beat per sample.
REQ-008 cnt_clr  input  1  synchronous clear of underflow_cnt.
REQ-009 din  input  32  packed sample: I = din[31:16], Q = din[15:0].
REQ-010 din_valid  input  1  din is valid.
REQ-011 din_rdy  output  1  FIFO can accept; transfer occurs when din_valid & din_rdy.
REQ-012 i_out, q_out  output  8 each  serdes I/Q byte, registered.
REQ-013 strb_out  output  8  serdes strobe byte, registered.
REQ-014 running  output  1  sequencer in RUN state.
REQ-015 underflow  output  1  one-cycle pulse per missing sample slot.
REQ-016 underflow_cnt  output  CNT_WIDTH  saturating count of underflow pulses.

Function
REQ-017 din_rdy SHALL equal enable & (FIFO not full); a full FIFO SHALL drop nothing, so no overflow condition exists.
REQ-018 FIFO SHALL accept a write and a read in the same cycle, including when full or empty-then-written; count unchanged on simultaneous write and read.
REQ-019 Sequencer states: IDLE, RUN, DRAIN.
REQ-020 IDLE->RUN when enable=1 and FIFO count >= FIFO_PRIME; IDLE outputs all zero.
REQ-021 RUN->DRAIN when enable=0 at a sample-slot boundary; DRAIN->IDLE after the current slot's last beat; enable=0 mid-sample SHALL finish that sample.
REQ-022 In IDLE with enable=0 the FIFO SHALL be flushed to empty.
REQ-023 Mode 0, per slot: beat H drives i_out=I[15:8], q_out=Q[15:8], strb_out=8'h80; beat L drives I[7:0], Q[7:0], strb_out=8'h00.
REQ-024 Mode 1, per slot (one beat): i_out=I[15:8], q_out=Q[15:8], strb_out=8'h80.
REQ-025 FIFO pop SHALL occur on the first beat of each slot; popped data appears on outputs after the next clock edge (1-cycle latency).
REQ-026 mode SHALL be sampled only at slot boundaries; a change mid-slot takes effect on the next slot.
REQ-027 Empty FIFO at a slot start in RUN SHALL assert underflow for one cycle and increment underflow_cnt, saturating at all-ones.
REQ-028 cnt_clr SHALL zero underflow_cnt; cnt_clr coincident with an underflow SHALL leave underflow_cnt = 0.
REQ-029 running SHALL be 1 in RUN and DRAIN, 0 in IDLE.

Reset
REQ-030 rstn low SHALL immediately force IDLE, FIFO empty, din_rdy=0, and all of i_out, q_out, strb_out, underflow, underflow_cnt, running = 0.
REQ-031 Reset mid-sample SHALL abandon that sample; after release, operation restarts from the IDLE priming rule.

Configuration
REQ-032 Macro ADRV9001_UNPACK_ZERO_STUFF_EN defined: an underflow slot SHALL emit a zero sample with the normal strobe cadence for the current mode, so framing is kept.
REQ-033 Macro undefined: an underflow slot SHALL emit zeros with strb_out=8'h00 for the whole slot, leaving a gap.

Verification
REQ-034 Mode 0, FIFO_PRIME=2: write 32'hA1B2C3D4 and 32'h11223344, enable=1 -> running=1; outputs (A1,C3,80), (B2,D4,00), (11,33,80), (22,44,00).
REQ-035 Mode 1, continuous valid stream -> one sample per cycle, strb_out=8'h80 every beat, din_rdy never drops while enable=1.
REQ-036 Starve the FIFO for 3 slots in RUN -> three underflow pulses, underflow_cnt=3, zero samples with strobe 80/00 (macro defined) or 00 (macro undefined).
REQ-037 enable falls on beat H of 32'hDEADBEEF -> beat L (AD,EF,00) still emitted, then IDLE, FIFO flushed, running=0.
REQ-038 rstn asserted mid-slot with FIFO full -> all outputs 0 asynchronously; after release, first output appears only after 2 new writes.
REQ-039 CNT_WIDTH=4, force 20 underflows -> underflow_cnt holds 4'hF; cnt_clr pulse -> 0.

Source files
------------

// File: rtl/adrv9001_tx_serdes_unpack_if.sv
// Sample stream into the ADRV9001 TX serdes unpacker: 32-bit packed I/Q words
// with a valid/ready handshake.
interface adrv9001_tx_serdes_unpack_if;
    logic [31:0] din;
    logic        din_valid;
    logic        din_rdy;

    modport master (output din, output din_valid, input din_rdy);
    modport slave  (input din, input din_valid, output din_rdy);
endinterface

// File: rtl/adrv9001_tx_serdes_unpack.sv
// Buffers packed I/Q samples and serialises them into serdes byte beats with strobe.
// Define ADRV9001_UNPACK_ZERO_STUFF_EN to keep strobe framing during underflow slots.
module adrv9001_tx_serdes_unpack #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_PRIME = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          mode,
    input  logic                          cnt_clr,
    adrv9001_tx_serdes_unpack_if.slave    din_bus,
    output logic [7:0]                    i_out,
    output logic [7:0]                    q_out,
    output logic [7:0]                    strb_out,
    output logic                          running,
    output logic                          underflow,
    output logic [CNT_WIDTH-1:0]          underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef ADRV9001_UNPACK_ZERO_STUFF_EN
    localparam logic [7:0] UF_STRB = 8'h80;
`else
    localparam logic [7:0] UF_STRB = 8'h00;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic        beat_l;
    logic [7:0]  lo_i;
    logic [7:0]  lo_q;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        wr_en;
    logic        slot_start;
    logic        pop;
    logic        flush;
    logic [31:0] head;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    // rstn gates ready directly so it drops the instant reset asserts
    assign din_bus.din_rdy = rstn & enable & ~full;
    assign wr_en      = din_bus.din_valid & din_bus.din_rdy;
    assign slot_start = (state == RUN) & ~beat_l & enable;
    assign pop        = slot_start & ~empty;
    assign flush      = (state == IDLE) & ~enable;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din_bus.din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // beat_l marks that the low half of a mode-0 slot is still owed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            beat_l    <= 1'b0;
            lo_i      <= '0;
            lo_q      <= '0;
            i_out     <= '0;
            q_out     <= '0;
            strb_out  <= '0;
            running   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    i_out    <= '0;
                    q_out    <= '0;
                    strb_out <= '0;
                    beat_l   <= 1'b0;
                    if (enable && (count >= (AW+1)'(FIFO_PRIME))) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat_l) begin
                        i_out    <= lo_i;
                        q_out    <= lo_q;
                        strb_out <= 8'h00;
                        beat_l   <= 1'b0;
                    end else if (!enable) begin
                        state    <= DRAIN;
                        i_out    <= '0;
                        q_out    <= '0;
                        strb_out <= '0;
                    end else begin
                        beat_l <= ~mode;
                        if (empty) begin
                            underflow <= 1'b1;
                            i_out     <= '0;
                            q_out     <= '0;
                            lo_i      <= '0;
                            lo_q      <= '0;
                            strb_out  <= UF_STRB;
                        end else begin
                            i_out    <= head[31:24];
                            q_out    <= head[15:8];
                            lo_i     <= head[23:16];
                            lo_q     <= head[7:0];
                            strb_out <= 8'h80;
                        end
                    end
                end
                DRAIN: begin
                    i_out    <= '0;
                    q_out    <= '0;
                    strb_out <= '0;
                    beat_l   <= 1'b0;
                    state    <= IDLE;
                    running  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Counts visible pulses, so a clear coincident with a pulse wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underflow_cnt <= '0;
        end else if (cnt_clr) begin
            underflow_cnt <= '0;
        end else if (underflow && !(&underflow_cnt)) begin
            underflow_cnt <= underflow_cnt + 1'b1;
        end
    end
endmodule
